// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared timing constants, helpers and types for the VGA raster
//            timing source. Defaults describe 640x480@60.
// Contents : c_* default timing constants, axis_total() and region_of()
//            helpers, sync_region_t region type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical)
    localparam int unsigned c_h_visible = 640;
    localparam int unsigned c_h_fp      = 16;
    localparam int unsigned c_h_sync    = 96;
    localparam int unsigned c_h_bp      = 48;
    localparam int unsigned c_v_visible = 480;
    localparam int unsigned c_v_fp      = 10;
    localparam int unsigned c_v_sync    = 2;
    localparam int unsigned c_v_bp      = 33;
    localparam int unsigned c_frame_w   = 6;

    // Counters are 10 bits wide, so no axis may exceed this many positions
    localparam int unsigned c_axis_limit = 1024;

    typedef enum logic [1:0] {
        VISIBLE     = 2'd0,
        FRONT_PORCH = 2'd1,
        SYNC        = 2'd2,
        BACK_PORCH  = 2'd3
    } sync_region_t;

    // Total positions per axis (pixels per line or lines per frame)
    function automatic int unsigned axis_total(
        input int unsigned visible,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return visible + fp + sync + bp;
    endfunction

    // Classify one axis position into its raster region
    function automatic sync_region_t region_of(
        input logic [9:0]  pos,
        input int unsigned visible,
        input int unsigned fp,
        input int unsigned sync
    );
        int unsigned p;
        p = 32'(pos);
        if (p < visible)
            return VISIBLE;
        else if (p < visible + fp)
            return FRONT_PORCH;
        else if (p < visible + fp + sync)
            return SYNC;
        else
            return BACK_PORCH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : One raster axis counter, 0..TOTAL-1, advancing on step and
//            wrapping to 0. Resets to TOTAL-1 (last position of the axis).
// Ports    : clk, rst_n (sync, active-low), step (advance request),
//            value (registered count), next_value (value after this edge),
//            wrap (step taken while at TOTAL-1).
// Revision : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL = 800
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [9:0] value,
    output logic [9:0] next_value,
    output logic       wrap
);

    localparam logic [9:0] c_last = 10'(TOTAL - 1);

    logic [9:0] r_value;
    logic       w_at_last;

    assign w_at_last = (r_value == c_last);
    assign wrap      = step && w_at_last;
    assign value     = r_value;

    // next_value is exposed so the parent can decode outputs from the value
    // this register is about to take, keeping every output aligned with it.
    always_comb begin
        next_value = r_value;
        if (step) begin
            next_value = w_at_last ? 10'd0 : r_value + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value <= c_last;
        end else begin
            r_value <= next_value;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Free-running raster timing source. Produces x/y coordinates,
//            visible-region flag, VGA syncs, line/frame start strobes and a
//            completed-frame counter. All outputs are registered and aligned.
// Ports    : clk, rst_n (sync, active-low), ena (pixel tick),
//            x, y (10-bit counters), active, hsync, vsync,
//            line_start, frame_start (one-clk strobes), frame_cnt.
// Config   : VGA_FRAME_CNT_EN - when defined, frame_cnt counts frames;
//            otherwise frame_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = c_h_visible,
    parameter int unsigned H_FP      = c_h_fp,
    parameter int unsigned H_SYNC    = c_h_sync,
    parameter int unsigned H_BP      = c_h_bp,
    parameter int unsigned V_VISIBLE = c_v_visible,
    parameter int unsigned V_FP      = c_v_fp,
    parameter int unsigned V_SYNC    = c_v_sync,
    parameter int unsigned V_BP      = c_v_bp,
    parameter logic        HSYNC_POL = 1'b0,
    parameter logic        VSYNC_POL = 1'b0,
    parameter int unsigned FRAME_W   = c_frame_w
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned c_h_total = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned c_v_total = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    generate
        if (c_h_total > c_axis_limit) begin : g_h_total_too_big
            $error("vga_timing_gen: horizontal total exceeds 10-bit counter range");
        end
        if (c_v_total > c_axis_limit) begin : g_v_total_too_big
            $error("vga_timing_gen: vertical total exceeds 10-bit counter range");
        end
    endgenerate

    logic [9:0]   w_h_next;
    logic [9:0]   w_v_next;
    logic         w_h_wrap;
    logic         w_v_wrap;
    logic         w_frame_wrap;
    sync_region_t w_h_region;
    sync_region_t w_v_region;

    logic r_active;
    logic r_hsync;
    logic r_vsync;
    logic r_line_start;
    logic r_frame_start;

    vga_axis_counter #(
        .TOTAL (c_h_total)
    ) u_h_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (ena),
        .value      (x),
        .next_value (w_h_next),
        .wrap       (w_h_wrap)
    );

    // The vertical axis advances only when a line completes
    vga_axis_counter #(
        .TOTAL (c_v_total)
    ) u_v_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (w_h_wrap),
        .value      (y),
        .next_value (w_v_next),
        .wrap       (w_v_wrap)
    );

    // Both wraps on one edge means the raster is entering (0,0)
    assign w_frame_wrap = w_h_wrap && w_v_wrap;

    assign w_h_region = region_of(w_h_next, H_VISIBLE, H_FP, H_SYNC);
    assign w_v_region = region_of(w_v_next, V_VISIBLE, V_FP, V_SYNC);

    // Decoding the next counter values means a disabled tick re-decodes the
    // current position, so active and the syncs hold without extra gating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_active      <= (w_h_region == VISIBLE) && (w_v_region == VISIBLE);
            r_hsync       <= (w_h_region == SYNC) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= (w_v_region == SYNC) ? VSYNC_POL : ~VSYNC_POL;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign active      = r_active;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
    // Resets to all-ones so the first frame after reset reads 0
    logic [FRAME_W-1:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '1;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule
`default_nettype wire
